// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field layout, PC width and fetch states.
package cpu_pkg;

  localparam int unsigned PC_W     = 16;
  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OPC_W    = 5;
  localparam int unsigned WAIT_W   = 11;
  localparam int unsigned OPC_LSB  = 27;
  localparam int unsigned XBIT_POS = 26;
  localparam int unsigned WAIT_LSB = 0;

  localparam logic [OPC_W-1:0] OPC_AND  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_PCR  = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b01111;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11111;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h7800_0000;

  typedef enum logic [1:0] {
    FS_RUN     = 2'd0,
    FS_STALLED = 2'd1,
    FS_HALTED  = 2'd2
  } fetch_state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: zero-bubble redirect, stall freeze with pending redirect, HALT latch.
module instr_fetch
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_re,
  output logic [PC_W-1:0]    imem_addr,
  output logic [OPC_W-1:0]   opcode,
  output logic               x_bit,
  output logic [WAIT_W-1:0]  wait_time,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    link_pc,
  output logic               halted
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] redir_tgt_q, redir_tgt_d;
  logic            valid_q, valid_d;
  logic            redir_pend_q, redir_pend_d;
  fetch_state_e    state_q, state_d;

  logic            halt_seen;
  logic            issue;
  logic [PC_W-1:0] issue_addr;

  // Memory holds its data while imem_re=0, so the presented word freezes on stall/halt.
  assign instr       = valid_q ? imem_rdata : NOP_INSTR;
  assign opcode      = instr[OPC_LSB +: OPC_W];
  assign x_bit       = instr[XBIT_POS];
  assign wait_time   = instr[WAIT_LSB +: WAIT_W];
  assign instr_valid = valid_q;
  assign link_pc     = fetch_pc_q + PC_W'(1);
  assign halted      = (state_q == FS_HALTED);

  // Any redirect (incoming or pending) overrides a presented HALT.
  assign halt_seen = valid_q && (opcode == OPC_HALT) && !redirect && !redir_pend_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    valid_d      = valid_q;
    redir_pend_d = redir_pend_q;
    redir_tgt_d  = redir_tgt_q;
    issue        = 1'b0;
    issue_addr   = pc_q;

    case (state_q)
      FS_RUN, FS_STALLED: begin
        if (halt_seen) begin
          state_d = FS_HALTED;
        end else if (stall) begin
          state_d = FS_STALLED;
          if (redirect) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = redirect_target;
          end
        end else begin
          state_d      = FS_RUN;
          issue        = 1'b1;
          redir_pend_d = 1'b0;
          if (redirect) begin
            issue_addr = redirect_target;
          end else if (redir_pend_q) begin
            issue_addr = redir_tgt_q;
          end
        end
      end
      FS_HALTED: state_d = FS_HALTED;
      default:   state_d = FS_RUN;
    endcase

    if (issue) begin
      pc_d       = issue_addr + PC_W'(1);
      fetch_pc_d = issue_addr;
      valid_d    = 1'b1;
    end
  end

  assign imem_re   = issue;
  assign imem_addr = issue_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FS_RUN;
      pc_q         <= '0;
      fetch_pc_q   <= '0;
      valid_q      <= 1'b0;
      redir_pend_q <= 1'b0;
      redir_tgt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      valid_q      <= valid_d;
      redir_pend_q <= redir_pend_d;
      redir_tgt_q  <= redir_tgt_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed table, corner sequences, randomized model run.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_target = '0;
  logic [31:0] imem_rdata = '0;
  logic        imem_re;
  logic [15:0] imem_addr;
  logic [4:0]  opcode;
  logic        x_bit;
  logic [10:0] wait_time;
  logic [31:0] instr;
  logic        instr_valid;
  logic [15:0] link_pc;
  logic        halted;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] HALT_W = {5'b11111, 27'd0};

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .imem_rdata(imem_rdata),
    .imem_re(imem_re), .imem_addr(imem_addr), .opcode(opcode), .x_bit(x_bit),
    .wait_time(wait_time), .instr(instr), .instr_valid(instr_valid),
    .link_pc(link_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: word k = {AND, k} unless overridden.
  logic [31:0] ovr [int];

  function automatic logic [31:0] mem_word(input int a);
    if (ovr.exists(a)) return ovr[a];
    return {OPC_AND, 11'd0, 16'(a)};
  endfunction

  always @(posedge clk) if (imem_re) imem_rdata <= mem_word(int'(imem_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_instr"}, instr, NOP_INSTR);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_link"}, 32'(link_pc), 32'd1);
    check({tag, "_halted"}, 32'(halted), 32'd0);
    check({tag, "_fields"}, {16'd0, opcode, x_bit, wait_time[9:0]}, {16'd0, 5'b01111, 1'b0, 10'd0});
  endtask

  // Ends on a negedge with rst_n just released; the next drive is the first post-reset cycle.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic s, input logic r, input logic [15:0] t);
    stall = s; redirect = r; redirect_target = t;
    #1;
  endtask

  // Behavioural model: integers for presented PC, next sequential PC and pending target.
  bit m_valid, m_halted;
  int m_fpc, m_next, m_pend;

  task automatic model_reset();
    m_valid = 0; m_halted = 0; m_fpc = 0; m_next = 0; m_pend = -1;
  endtask

  task automatic model_step(input logic s, input logic r, input logic [15:0] t);
    logic [31:0] w;
    bit iss;
    int a;
    drive(s, r, t);
    w = m_valid ? mem_word(m_fpc) : NOP_INSTR;
    check("rnd_instr", instr, w);
    check("rnd_valid", 32'(instr_valid), 32'(m_valid));
    check("rnd_link", 32'(link_pc), (m_fpc + 1) & 32'hFFFF);
    check("rnd_halted", 32'(halted), 32'(m_halted));
    iss = 0; a = 0;
    if (!m_halted) begin
      if (m_valid && w[31:27] == 5'b11111 && !r && m_pend < 0) m_halted = 1;
      else if (s) begin
        if (r) m_pend = int'(t);
      end else begin
        iss = 1;
        a = r ? int'(t) : (m_pend >= 0 ? m_pend : m_next);
      end
    end
    check("rnd_re", 32'(imem_re), 32'(iss));
    if (iss) begin
      check("rnd_addr", 32'(imem_addr), 32'(a));
      m_valid = 1; m_fpc = a; m_next = (a + 1) & 'hFFFF; m_pend = -1;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [15:0] tgt;
    logic        exp_re;
    logic [15:0] exp_addr;
    logic        exp_valid;
    logic [15:0] exp_ppc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic s, input logic r, input logic [15:0] t,
                              input logic re, input logic [15:0] ad,
                              input logic v, input logic [15:0] ppc);
    vec_t e;
    e.stall = s; e.redir = r; e.tgt = t; e.exp_re = re; e.exp_addr = ad;
    e.exp_valid = v; e.exp_ppc = ppc;
    tbl.push_back(e);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit found;
    logic [31:0] exp_w;

    // Reset release, 5-cycle stall, redirects, pending redirect, 0xFFFF wrap.
    add(0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000);
    add(0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);
    add(0, 0, 16'h0000, 1, 16'h0002, 1, 16'h0001);
    add(0, 0, 16'h0000, 1, 16'h0003, 1, 16'h0002);
    add(0, 0, 16'h0000, 1, 16'h0004, 1, 16'h0003);
    for (int i = 0; i < 5; i++) add(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004);
    add(0, 0, 16'h0000, 1, 16'h0005, 1, 16'h0004);
    add(0, 1, 16'h0100, 1, 16'h0100, 1, 16'h0005);
    add(0, 0, 16'h0000, 1, 16'h0101, 1, 16'h0100);
    add(1, 1, 16'h0200, 0, 16'h0000, 1, 16'h0101);
    add(1, 1, 16'h0300, 0, 16'h0000, 1, 16'h0101);
    add(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0101);
    add(0, 0, 16'h0000, 1, 16'h0300, 1, 16'h0101);
    add(0, 0, 16'h0000, 1, 16'h0301, 1, 16'h0300);
    add(0, 1, 16'hFFFF, 1, 16'hFFFF, 1, 16'h0301);
    add(0, 0, 16'h0000, 1, 16'h0000, 1, 16'hFFFF);
    add(0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000);

    do_reset("rst0");
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].tgt);
      check($sformatf("tbl%0d_re", i), 32'(imem_re), 32'(tbl[i].exp_re));
      if (tbl[i].exp_re) check($sformatf("tbl%0d_addr", i), 32'(imem_addr), 32'(tbl[i].exp_addr));
      check($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
      exp_w = tbl[i].exp_valid ? mem_word(int'(tbl[i].exp_ppc)) : NOP_INSTR;
      check($sformatf("tbl%0d_instr", i), instr, exp_w);
      check($sformatf("tbl%0d_link", i), 32'(link_pc), 32'(16'(tbl[i].exp_ppc + 16'd1)));
      @(negedge clk);
    end

    // HALT at address 6: halts, ignores stall/redirect, reset restarts at 0.
    ovr.delete();
    ovr[6] = HALT_W;
    do_reset("rst1");
    found = 0;
    for (n = 0; n < 20; n++) begin
      drive(0, 0, 16'h0000);
      if (instr_valid && opcode == OPC_HALT) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("halt_found", 32'(found), 32'd1);
    check("halt_cycle", 32'(n), 32'd7);
    check("halt_pres_halted", 32'(halted), 32'd0);
    check("halt_pres_re", 32'(imem_re), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
      check($sformatf("halted%0d", i), 32'(halted), 32'd1);
      check($sformatf("halted%0d_re", i), 32'(imem_re), 32'd0);
      check($sformatf("halted%0d_instr", i), instr, HALT_W);
    end
    @(negedge clk);
    do_reset("rst2");
    drive(0, 0, 16'h0000);
    check("restart_re", 32'(imem_re), 32'd1);
    check("restart_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);

    // HALT with redirect does not halt; HALT with stall does.
    ovr.delete();
    ovr[2] = HALT_W;
    ovr['h41] = HALT_W;
    do_reset("rst3");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0000);
      @(negedge clk);
    end
    drive(0, 1, 16'h0040);
    check("hr_instr", instr, HALT_W);
    check("hr_re", 32'(imem_re), 32'd1);
    check("hr_addr", 32'(imem_addr), 32'h40);
    @(negedge clk);
    drive(0, 0, 16'h0000);
    check("hr_halted", 32'(halted), 32'd0);
    check("hr_instr2", instr, mem_word('h40));
    check("hr_link", 32'(link_pc), 32'h41);
    check("hr_addr2", 32'(imem_addr), 32'h41);
    @(negedge clk);
    drive(1, 0, 16'h0000);
    check("hs_instr", instr, HALT_W);
    check("hs_re", 32'(imem_re), 32'd0);
    @(negedge clk);
    drive(0, 0, 16'h0000);
    check("hs_halted", 32'(halted), 32'd1);
    check("hs_re2", 32'(imem_re), 32'd0);
    @(negedge clk);

    // Reset during a stall with a pending redirect discards the redirect.
    ovr.delete();
    do_reset("rst4");
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0000);
      @(negedge clk);
    end
    drive(1, 1, 16'h0500);
    @(negedge clk);
    drive(1, 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 16'h0000);
    check("rm_re", 32'(imem_re), 32'd1);
    check("rm_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    drive(0, 0, 16'h0000);
    check("rm_addr2", 32'(imem_addr), 32'd1);
    check("rm_instr", instr, mem_word(0));
    @(negedge clk);

    // Randomized run against the model.
    ovr.delete();
    ovr['h13] = HALT_W;
    ovr['h2A] = HALT_W;
    do_reset("rst5");
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && $urandom_range(0, 7) == 0) begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0;
        #1 check_reset_vals("rnd_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
      end else begin
        model_step(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) < 2),
                   ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 63)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
